// File: rtl/projection_sequencer_pkg.sv
// Shared AR-pipeline definitions: sequencer states, screen limits and
// the on-screen test applied to projected points.
package projection_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_WAIT,
    S_EMIT
  } seq_state_t;

  localparam int SCREEN_X_MAX = 1023;
  localparam int SCREEN_Y_MAX = 767;

  localparam int unsigned LANE_W     = 16;
  localparam int unsigned COORD_W    = 32;
  localparam int unsigned ORIGIN_X_W = 11;
  localparam int unsigned ORIGIN_Y_W = 10;
  localparam int unsigned COLOR_W    = 4;

  // Signed 32-bit window test against the visible screen area.
  function automatic logic on_screen(input logic signed [COORD_W-1:0] x,
                                     input logic signed [COORD_W-1:0] y);
    return (x >= 0) && (x <= SCREEN_X_MAX) && (y >= 0) && (y <= SCREEN_Y_MAX);
  endfunction

endpackage

// File: rtl/projection_sequencer.sv
// Walks the virtual-point table once per frame, feeds operands to the external
// projection datapath and streams the projected points out with a valid/ready handshake.
module projection_sequencer
  import projection_sequencer_pkg::*;
#(
  parameter int unsigned N_TRACKING_POINTS = 4,
  parameter int unsigned N_VIRTUAL_POINTS  = 8,
  parameter int unsigned PROJ_LATENCY      = 1
) (
  input  logic                                           clk_in,
  input  logic                                           rst_in,
  input  logic                                           start,
  input  logic                                           abort,
  input  logic [(N_TRACKING_POINTS-1)*LANE_W-1:0]        x_vec_in,
  input  logic [(N_TRACKING_POINTS-1)*LANE_W-1:0]        y_vec_in,
  input  logic [ORIGIN_X_W-1:0]                          x_origin_in,
  input  logic [ORIGIN_Y_W-1:0]                          y_origin_in,
  output logic [$clog2(N_VIRTUAL_POINTS)-1:0]            pt_addr,
  input  logic [(N_TRACKING_POINTS-1)*LANE_W-1:0]        pt_scalars,
  input  logic [COLOR_W-1:0]                             pt_color,
  output logic [(N_TRACKING_POINTS-1)*LANE_W-1:0]        proj_x_vec,
  output logic [(N_TRACKING_POINTS-1)*LANE_W-1:0]        proj_y_vec,
  output logic [(N_TRACKING_POINTS-1)*LANE_W-1:0]        proj_scalars,
  output logic [COLOR_W-1:0]                             proj_color,
  output logic [ORIGIN_X_W-1:0]                          proj_x_origin,
  output logic [ORIGIN_Y_W-1:0]                          proj_y_origin,
  input  logic signed [COORD_W-1:0]                      x_proj,
  input  logic signed [COORD_W-1:0]                      y_proj,
  input  logic [COLOR_W-1:0]                             color_proj,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic signed [COORD_W-1:0]                      out_x,
  output logic signed [COORD_W-1:0]                      out_y,
  output logic [COLOR_W-1:0]                             out_color,
  output logic                                           out_on_screen,
  output logic [$clog2(N_VIRTUAL_POINTS)-1:0]            out_index,
  output logic                                           busy,
  output logic                                           done
);

  localparam int unsigned BASIS_W = (N_TRACKING_POINTS - 1) * LANE_W;
  localparam int unsigned IDX_W   = $clog2(N_VIRTUAL_POINTS);
  localparam int unsigned CNT_W   = (PROJ_LATENCY > 1) ? $clog2(PROJ_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_VIRTUAL_POINTS - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(PROJ_LATENCY - 1);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_index;
  logic [IDX_W-1:0]   w_index_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   r_pt_addr;
  logic [IDX_W-1:0]   w_pt_addr_nxt;
  logic               w_load_ops;
  logic               w_load_pt;
  logic               w_done_nxt;

  logic [BASIS_W-1:0]    r_x_vec;
  logic [BASIS_W-1:0]    r_y_vec;
  logic [BASIS_W-1:0]    r_scalars;
  logic [COLOR_W-1:0]    r_color;
  logic [ORIGIN_X_W-1:0] r_x_origin;
  logic [ORIGIN_Y_W-1:0] r_y_origin;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_done;

  // Next-state and datapath-control decode; abort overrides everything outside IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    w_cnt_nxt     = r_cnt;
    w_pt_addr_nxt = r_pt_addr;
    w_load_ops    = 1'b0;
    w_load_pt     = 1'b0;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt   = S_FETCH;
          w_index_nxt   = '0;
          w_pt_addr_nxt = '0;
          w_load_ops    = 1'b1;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_state_nxt = S_WAIT;
        w_load_pt   = 1'b1;
        w_cnt_nxt   = WAIT_LOAD;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_EMIT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (r_index == LAST_IDX) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_FETCH;
            w_index_nxt   = r_index + IDX_W'(1);
            w_pt_addr_nxt = r_index + IDX_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_load_pt   = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  // State, counters, operand holding registers and registered status.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_cnt       <= '0;
      r_pt_addr   <= '0;
      r_x_vec     <= '0;
      r_y_vec     <= '0;
      r_scalars   <= '0;
      r_color     <= '0;
      r_x_origin  <= '0;
      r_y_origin  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pt_addr   <= w_pt_addr_nxt;
      r_out_valid <= (w_state_nxt == S_EMIT);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      if (w_load_ops) begin
        r_x_vec    <= x_vec_in;
        r_y_vec    <= y_vec_in;
        r_x_origin <= x_origin_in;
        r_y_origin <= y_origin_in;
      end
      if (w_load_pt) begin
        r_scalars <= pt_scalars;
        r_color   <= pt_color;
      end
    end
  end

  assign pt_addr       = r_pt_addr;
  assign proj_x_vec    = r_x_vec;
  assign proj_y_vec    = r_y_vec;
  assign proj_scalars  = r_scalars;
  assign proj_color    = r_color;
  assign proj_x_origin = r_x_origin;
  assign proj_y_origin = r_y_origin;

  // Result stream: projection results pass straight through while operands are held.
  assign out_valid     = r_out_valid;
  assign out_x         = x_proj;
  assign out_y         = y_proj;
  assign out_color     = color_proj;
  assign out_on_screen = on_screen(x_proj, y_proj);
  assign out_index     = r_index;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
